dca_bitserial_job_scheduler: RTL and testbench

- Shares one bit-serial multiply/accumulate sequencing engine between NUM_REQ requesters.
- Each requester submits an A bit-mask and a B bit-mask as a job.
- Arbitration is round-robin. The winning job is latched, the engine gets a one-cycle start pulse, the scheduler waits for the engine's done pulse, then returns a tagged response with the measured run length.
- Sits between the per-lane job sources and the engine instance in the DCA cluster.

---
 rtl/dca_sched_pkg.sv | 19 +
 rtl/dca_rr_arbiter.sv | 43 ++++
 rtl/dca_bitserial_job_scheduler.sv | 162 ++++++++++++++++
 tb/tb_dca_bitserial_job_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_sched_pkg.sv
// Shared definitions for the DCA bit-serial job scheduler: FSM encodings,
// id-width derivation and the default run-length counter width.
package dca_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  localparam int CYCLE_WIDTH_DEF = 16;

  // Requester index width; a single-bit id is kept even for trivially small pools.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dca_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module dca_rr_arbiter
  import dca_sched_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                gnt_en,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_idx
);

  localparam logic [ID_WIDTH:0] NREQ_L = (ID_WIDTH + 1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [ID_WIDTH:0]  off_sel;
  logic [ID_WIDTH:0]  sum;
  logic               found;

  // Rotate so that bit 0 is the requester the pointer names.
  assign rot = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    found   = 1'b0;
    off_sel = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && rot[off]) begin
        found   = 1'b1;
        off_sel = (ID_WIDTH + 1)'(off);
      end
    end
    sum = {1'b0, ptr} + off_sel;
    if (sum >= NREQ_L) begin
      sum = sum - NREQ_L;
    end
    gnt_idx = sum[ID_WIDTH-1:0];
    gnt     = (found && gnt_en) ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/dca_bitserial_job_scheduler.sv
// Round-robin job scheduler sharing one bit-serial MAC engine between NUM_REQ
// requesters. Optional zero-mask bypass: define DCA_SCHED_ZERO_SKIP_EN.
// Handshakes: a transfer happens on a cycle where valid and ready are both high;
// ready never depends on valid of the same interface beyond arbitration.
module dca_bitserial_job_scheduler
  import dca_sched_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  A_WIDTH     = 8,
  parameter int  B_WIDTH     = 8,
  parameter int  CYCLE_WIDTH = CYCLE_WIDTH_DEF,
  localparam int ID_WIDTH    = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rstnn,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a_mask,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b_mask,
  output logic                       eng_enable,
  output logic                       eng_start,
  output logic [A_WIDTH-1:0]         eng_a_mask,
  output logic [B_WIDTH-1:0]         eng_b_mask,
  input  logic                       eng_done,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [CYCLE_WIDTH-1:0]     rsp_cycles,
  output logic                       rsp_skipped,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  sched_state_e             state_q, state_d;
  logic [ID_WIDTH-1:0]      ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic [A_WIDTH-1:0]       a_q, a_d;
  logic [B_WIDTH-1:0]       b_q, b_d;
  logic [CYCLE_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CYCLE_WIDTH-1:0]   cyc_q, cyc_d;
`ifdef DCA_SCHED_ZERO_SKIP_EN
  logic                     skip_q, skip_d;
`endif

  logic [NUM_REQ-1:0]       gnt;
  logic [ID_WIDTH-1:0]      gnt_idx;
  logic                     xfer;
  logic [A_WIDTH-1:0]       a_sel;
  logic [B_WIDTH-1:0]       b_sel;
  logic [ID_WIDTH-1:0]      ptr_next;
  logic [CYCLE_WIDTH-1:0]   cnt_inc;

  dca_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_en  (enable && (state_q == ST_IDLE)),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign xfer     = |gnt;
  assign a_sel    = A_WIDTH'(req_a_mask >> (gnt_idx * A_WIDTH));
  assign b_sel    = B_WIDTH'(req_b_mask >> (gnt_idx * B_WIDTH));
  assign ptr_next = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
`ifdef DCA_SCHED_ZERO_SKIP_EN
    skip_d  = skip_q;
`endif
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            a_d     = a_sel;
            b_d     = b_sel;
            id_d    = gnt_idx;
            ptr_d   = ptr_next;
            state_d = ST_ISSUE;
`ifdef DCA_SCHED_ZERO_SKIP_EN
            skip_d  = 1'b0;
            if ((a_sel == '0) || (b_sel == '0)) begin
              state_d = ST_RESP;
              cyc_d   = '0;
              skip_d  = 1'b1;
            end
`endif
          end
        end
        ST_ISSUE: begin
          cnt_d   = CYCLE_WIDTH'(1);
          state_d = ST_RUN;
        end
        ST_RUN: begin
          cnt_d = cnt_inc;
          // The done cycle itself counts toward the reported run length.
          if (eng_done) begin
            cyc_d   = cnt_inc;
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
`ifdef DCA_SCHED_ZERO_SKIP_EN
      skip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
`ifdef DCA_SCHED_ZERO_SKIP_EN
      skip_q  <= skip_d;
`endif
    end
  end

  assign req_ready  = gnt;
  assign eng_enable = enable;
  assign eng_start  = (state_q == ST_ISSUE);
  assign eng_a_mask = a_q;
  assign eng_b_mask = b_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_cycles = cyc_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;
`ifdef DCA_SCHED_ZERO_SKIP_EN
  assign rsp_skipped = skip_q;
`else
  assign rsp_skipped = 1'b0;
`endif

endmodule

// File: tb/tb_dca_bitserial_job_scheduler.sv
// Directed bench for dca_bitserial_job_scheduler; the engine is played inline
// by the stimulus sequence. CYCLE_WIDTH is narrowed so saturation is reachable.
module tb_dca_bitserial_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int AW      = 8;
  localparam int BW      = 8;
  localparam int CW      = 6;
  localparam int IW      = 2;

  logic                  clk;
  logic                  rstnn;
  logic                  enable;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_a_mask;
  logic [NUM_REQ*BW-1:0] req_b_mask;
  logic                  eng_enable;
  logic                  eng_start;
  logic [AW-1:0]         eng_a_mask;
  logic [BW-1:0]         eng_b_mask;
  logic                  eng_done;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [CW-1:0]         rsp_cycles;
  logic                  rsp_skipped;
  logic                  busy;
  logic [1:0]            dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  dca_bitserial_job_scheduler #(
    .NUM_REQ(NUM_REQ), .A_WIDTH(AW), .B_WIDTH(BW), .CYCLE_WIDTH(CW)
  ) dut (
    .clk(clk), .rstnn(rstnn), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_mask(req_a_mask), .req_b_mask(req_b_mask),
    .eng_enable(eng_enable), .eng_start(eng_start),
    .eng_a_mask(eng_a_mask), .eng_b_mask(eng_b_mask), .eng_done(eng_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cycles(rsp_cycles), .rsp_skipped(rsp_skipped),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic set_masks();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a_mask[i*AW +: AW] = AW'(8'h10 + i);
      req_b_mask[i*BW +: BW] = BW'(8'h20 + i);
    end
  endtask

  task automatic do_reset();
    rstnn = 1'b0;
    repeat (2) tick();
    rstnn = 1'b1;
    tick();
  endtask

  // Entered in the eng_start cycle (inclusive cycle 1); raises done in cycle n.
  task automatic run_job(input int n);
    int starts;
    starts = 0;
    for (int i = 2; i <= n; i++) begin
      tick();
      if (eng_start) starts++;
      if (i == n) eng_done = 1'b1;
    end
    tick();
    eng_done = 1'b0;
    chk("job_extra_start", starts, 0);
    chk("job_resp_state", dbg_state, 3);
  endtask

  initial begin
    rstnn = 1'b0; enable = 1'b1; req_valid = '0; eng_done = 1'b0; rsp_ready = 1'b0;
    req_a_mask = '0; req_b_mask = '0;
    repeat (2) tick();
    rstnn = 1'b1;
    tick();

    // reset state
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_a_mask", eng_a_mask, 0);
    chk("rst_b_mask", eng_b_mask, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_cycles", rsp_cycles, 0);
    chk("rst_rsp_skipped", rsp_skipped, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_eng_enable", eng_enable, 1);

    // single job, 20-cycle engine run
    req_a_mask = {8'hAA, 8'hAA, 8'hAA, 8'h05};
    req_b_mask = {8'hBB, 8'hBB, 8'hBB, 8'h03};
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_start", eng_start, 1);
    chk("t1_a", eng_a_mask, 8'h05);
    chk("t1_b", eng_b_mask, 8'h03);
    chk("t1_busy", busy, 1);
    chk("t1_ready_issue", req_ready, 0);
    run_job(20);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_cycles", rsp_cycles, 20);
    chk("t1_rsp_skipped", rsp_skipped, 0);
    chk("t1_a_hold", eng_a_mask, 8'h05);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_rsp_drop", rsp_valid, 0);

    // round-robin fairness from a fresh pointer
    do_reset();
    set_masks();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("rr_grant", req_ready, 32'(1 << (j % 4)));
      tick();
      chk("rr_a", eng_a_mask, 32'(8'h10 + (j % 4)));
      chk("rr_b", eng_b_mask, 32'(8'h20 + (j % 4)));
      run_job(3);
      chk("rr_id", rsp_id, 32'(j % 4));
      chk("rr_cycles", rsp_cycles, 3);
      tick();
    end

    // response backpressure; stray done in RESP is ignored
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    chk("bp_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1111;
    run_job(5);
    for (int k = 0; k < 10; k++) begin
      eng_done = (k == 3);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_cycles", rsp_cycles, 5);
      chk("bp_busy", busy, 1);
      chk("bp_no_ready", req_ready, 0);
      tick();
    end
    eng_done = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_same_cycle", req_ready, 0);
    tick();
    chk("bp_next_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("bp_next_a", eng_a_mask, 8'h11);
    run_job(2);
    chk("bp_next_id", rsp_id, 1);
    chk("bp_next_cycles", rsp_cycles, 2);
    tick();

    // enable freeze in IDLE, ISSUE and RUN
    req_valid = 4'b0100; enable = 1'b0;
    #1;
    chk("en_idle_ready", req_ready, 0);
    tick();
    chk("en_idle_state", dbg_state, 0);
    enable = 1'b1;
    #1;
    chk("en_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0; enable = 1'b0;
    tick();
    chk("en_issue_hold", eng_start, 1);
    chk("en_issue_state", dbg_state, 1);
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("en_run_state", dbg_state, 2);
      chk("en_eng_enable", eng_enable, 0);
    end
    enable = 1'b1;
    for (int i = 3; i <= 12; i++) begin
      if (i == 12) eng_done = 1'b1;
      tick();
    end
    eng_done = 1'b0;
    chk("en_rsp_valid", rsp_valid, 1);
    chk("en_rsp_cycles", rsp_cycles, 12);
    chk("en_rsp_id", rsp_id, 2);
    tick();

    // asynchronous reset mid-RUN (pointer is 3 before this job, 1 after)
    req_valid = 4'b0001;
    #1;
    chk("rr_wrap_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    rstnn = 1'b0;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_state", dbg_state, 0);
    chk("ar_eng_start", eng_start, 0);
    chk("ar_a_mask", eng_a_mask, 0);
    chk("ar_rsp_cycles", rsp_cycles, 0);
    tick();
    rstnn = 1'b1;
    tick();
    chk("ar_no_rsp", rsp_valid, 0);
    req_valid = 4'b0101;
    #1;
    chk("ar_ptr_zero", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("ar_start", eng_start, 1);
    run_job(4);
    chk("ar_rsp_id", rsp_id, 0);
    chk("ar_rsp_cycles", rsp_cycles, 4);
    tick();

    // done while idle is ignored
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("idle_done_state", dbg_state, 0);
    chk("idle_done_rsp", rsp_valid, 0);

    // run-length saturation at 2**CW-1
    req_valid = 4'b0010;
    #1;
    chk("sat_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    run_job(70);
    chk("sat_cycles", rsp_cycles, 63);
    chk("sat_id", rsp_id, 1);
    tick();

    // zero A mask on requester 2
    req_a_mask[2*AW +: AW] = 8'h00;
    req_b_mask[2*BW +: BW] = 8'hFF;
    req_valid = 4'b0100;
    #1;
    chk("zm_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
`ifdef DCA_SCHED_ZERO_SKIP_EN
    chk("zm_no_start", eng_start, 0);
    chk("zm_state", dbg_state, 3);
    chk("zm_rsp_valid", rsp_valid, 1);
    chk("zm_skipped", rsp_skipped, 1);
    chk("zm_cycles", rsp_cycles, 0);
    chk("zm_id", rsp_id, 2);
    tick();
    chk("zm_idle", busy, 0);
`else
    chk("zm_start", eng_start, 1);
    chk("zm_a", eng_a_mask, 0);
    chk("zm_b", eng_b_mask, 8'hFF);
    run_job(3);
    chk("zm_skipped", rsp_skipped, 0);
    chk("zm_cycles", rsp_cycles, 3);
    chk("zm_id", rsp_id, 2);
    tick();
    chk("zm_idle", busy, 0);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
